pipe_skid_buf: RTL
==================

PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 SHALL have parameter WIDTH, default XLEN: width of the data payload in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-004 SHALL have port flush  input  1  discards all held beats; active high.
REQ-005 SHALL have port in_valid  input  1  upstream beat present.
REQ-006 SHALL have port in_ready  output  1  buffer can accept a beat this cycle.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port out_valid  output  1  downstream beat present.
REQ-009 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.

Function
REQ-011 SHALL define an input fire as in_valid & in_ready, and an output fire as out_valid & out_ready, both sampled at posedge clk.
REQ-012 SHALL hold two storage registers, main and skid, and a state machine with states EMPTY (0 beats), BUSY (main holds the beat), and FULL (main and skid both hold beats).
REQ-013 SHALL drive in_ready = (state != FULL), out_valid = (state != EMPTY), and out_data = main; all are decoded from registers only, with no combinational path from in_* or out_ready.
REQ-014 SHALL make the following transitions from EMPTY:
- input fire -> BUSY, main <= in_data.
- no input fire -> stay in EMPTY.
REQ-015 SHALL make the following transitions from BUSY:
- input fire and output fire -> BUSY, main <= in_data.
- input fire only -> FULL, skid <= in_data.
- output fire only -> EMPTY.
- neither -> stay in BUSY.
REQ-016 SHALL make the following transitions from FULL:
- output fire -> BUSY, main <= skid.
- no output fire -> stay in FULL; main and skid hold.
REQ-017 SHALL have a latency of 1 cycle: a beat accepted at edge N appears on out_data after edge N.
REQ-018 SHALL sustain 1 beat/cycle throughput while out_ready is held high.
REQ-019 SHALL deliver beats in acceptance order, with none lost or duplicated.
REQ-020 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL give flush priority over every other event: on a flush edge the next state is EMPTY, and any beat presented in the same cycle is dropped, even though in_ready=1.
REQ-022 SHALL leave the contents of main and skid unchanged by flush; they are don't-care while the state is EMPTY.
REQ-023 SHALL ignore in_data whenever in_valid=0.

Reset
REQ-024 SHALL, on a posedge clk with reset=0, set state=EMPTY and main=skid='0, giving out_valid=0, in_ready=1 and out_data='0 from the next cycle.
REQ-025 SHALL give reset priority over flush and over both fires.
REQ-026 SHALL, when reset is asserted mid-operation, discard all held beats; no beat is output after the reset edge.

Configuration
REQ-027 SHALL use the macro PIPE_SKID_FLUSH_EN to compile the flush feature in or out.
REQ-028 SHALL, when PIPE_SKID_FLUSH_EN is defined, implement the flush port per REQ-021 and REQ-022.
REQ-029 SHALL, when PIPE_SKID_FLUSH_EN is undefined, still present the flush port but ignore it, leaving behaviour identical to flush tied to 0.

Structure
REQ-030 SHALL declare the enum skid_state_e {EMPTY, BUSY, FULL} in brisc_pkg, and take XLEN from brisc_pkg.
REQ-031 SHALL contain no sub-module; the state machine and the two data registers SHALL be inline in a single always_ff block plus a decode block.

Verification
REQ-032 SHALL be covered by the following directed scenarios:
- Streaming: out_ready=1; send 0x11, 0x22, 0x33 on consecutive cycles -> out_data = 0x11, 0x22, 0x33 on the following consecutive cycles; in_ready stays 1.
- Backpressure: out_ready=0; send 0xA, 0xB -> state FULL, in_ready=0, out_data=0xA; a third beat 0xC is held upstream. Then out_ready=1 -> outputs 0xA, 0xB, 0xC in order, with none lost.
- Simultaneous fire in BUSY: hold 0x5; at the same edge an output fire and input 0x6 -> out_valid=1 and out_data=0x6 the next cycle; state remains BUSY.
- Flush in FULL with in_valid=1 and in_data=0x77 (flush enabled) -> next cycle out_valid=0, in_ready=1; 0x77 is never output.
- Reset: reset=0 while FULL -> next cycle out_valid=0, in_ready=1, out_data=0. Reset asserted together with flush and input fire -> same result.
- Flush disabled build: assert flush in BUSY holding 0x9 -> out_valid stays 1 and out_data stays 0x9.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared definitions for the brisc pipeline blocks: datapath width and the
// skid-buffer occupancy states.
package brisc_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: registered valid/ready on both sides, 1-cycle latency.
// Optional flush support is compiled in when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_buf
    import brisc_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

`ifdef PIPE_SKID_FLUSH_EN
    localparam logic FLUSH_EN = 1'b1;
`else
    localparam logic FLUSH_EN = 1'b0;
`endif

    skid_state_e      r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    skid_state_e      w_state_nxt;
    logic [WIDTH-1:0] w_main_nxt;
    logic [WIDTH-1:0] w_skid_nxt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_flush;

    // Handshake outputs depend only on the state register.
    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_flush    = flush & FLUSH_EN;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        // Flush only empties the buffer; stored payloads are left untouched.
        if (w_flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = BUSY;
                        w_main_nxt  = in_data;
                    end
                end
                BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_nxt = in_data;
                    end else if (w_in_fire) begin
                        w_state_nxt = FULL;
                        w_skid_nxt  = in_data;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = BUSY;
                        w_main_nxt  = r_skid;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

endmodule
